// File: rtl/sixteen_to_four_event_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sixteen_to_four_event_encoder_pkg
// Brief    : Shared sizes and the index-to-one-hot helper for the event encoder.
// Revision : 1.0
// ============================================================================
package sixteen_to_four_event_encoder_pkg;

    localparam int N = 16;
    localparam int W = 4;

    function automatic logic [N-1:0] idx_to_onehot(input logic [W-1:0] idx);
        logic [N-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sixteen_to_four_event_encoder_four_to_two_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module   : four_to_two_priority_encoder
// Brief    : 4-bit highest-index-wins priority encoder with an any flag.
// Revision : 1.0
// ============================================================================
module four_to_two_priority_encoder (
    input  logic [3:0] bits,
    output logic [1:0] idx,
    output logic       any
);

    always_comb begin
        any = |bits;
        idx = 2'd0;
        if (bits[3])      idx = 2'd3;
        else if (bits[2]) idx = 2'd2;
        else if (bits[1]) idx = 2'd1;
    end

endmodule
`default_nettype wire

// File: rtl/sixteen_to_four_event_encoder.sv
`default_nettype none
// ============================================================================
// Module   : sixteen_to_four_event_encoder
// Brief    : Buffers 16 event lines and issues their indices, highest first,
//            over a valid/ready handshake.
// Revision : 1.0
// ============================================================================
module sixteen_to_four_event_encoder
    import sixteen_to_four_event_encoder_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [W-1:0] code,
    output logic         valid,
    input  logic         ready,
    output logic         pending_any,
    output logic         overflow,
    input  logic         ovf_clr
);

    logic [N-1:0] r_pending;
    logic [W-1:0] r_code;
    logic         r_valid;
    logic         r_overflow;

    logic [1:0]   w_nib_idx [4];
    logic [3:0]   w_nib_any;
    logic [1:0]   w_hi_idx;
    logic         w_any;
    logic [W-1:0] w_sel;
    logic         w_load;
    logic [N-1:0] w_issue_oh;
    logic [N-1:0] w_req_en;

    // Two-level tree: one encoder per nibble, then one over the nibble flags.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_nibble
            four_to_two_priority_encoder u_nib (
                .bits (r_pending[4*gi +: 4]),
                .idx  (w_nib_idx[gi]),
                .any  (w_nib_any[gi])
            );
        end
    endgenerate

    four_to_two_priority_encoder u_top (
        .bits (w_nib_any),
        .idx  (w_hi_idx),
        .any  (w_any)
    );

    assign w_sel      = {w_hi_idx, w_nib_idx[w_hi_idx]};
    assign w_load     = en & (~r_valid | ready);
    assign w_issue_oh = (w_load & w_any) ? idx_to_onehot(w_sel) : '0;
    assign w_req_en   = req & {N{en}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= '0;
            r_code     <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            // A request landing on the bit being issued re-arms it as a fresh event.
            r_pending  <= (r_pending & ~w_issue_oh) | w_req_en;
            r_overflow <= (r_overflow & ~ovf_clr) | (|(w_req_en & r_pending & ~w_issue_oh));
            if (w_load) begin
                r_valid <= w_any;
                if (w_any) r_code <= w_sel;
            end
        end
    end

    assign code        = r_code;
    assign valid       = r_valid;
    assign overflow    = r_overflow;
    assign pending_any = |r_pending;

endmodule
`default_nettype wire

// File: tb/tb_sixteen_to_four_event_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sixteen_to_four_event_encoder
// Brief    : Scoreboard bench for the 16-to-4 event encoder.
// Revision : 1.0
// ============================================================================
module tb_sixteen_to_four_event_encoder;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] req;
    logic [3:0]  code;
    logic        valid;
    logic        ready;
    logic        pending_any;
    logic        overflow;
    logic        ovf_clr;

    int          n_cmp;
    int          n_err;
    int unsigned sb_q [$];

    logic [15:0] m_pend;
    logic        m_valid;
    logic [3:0]  m_code;
    logic        m_ovf;

    sixteen_to_four_event_encoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .req         (req),
        .code        (code),
        .valid       (valid),
        .ready       (ready),
        .pending_any (pending_any),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend  = '0;
        m_valid = 1'b0;
        m_code  = '0;
        m_ovf   = 1'b0;
    endtask

    // One clock: drive inputs, score any accept, advance model, compare after edge.
    task automatic step(input logic [15:0] r, input logic e, input logic rd, input logic c);
        logic        load;
        logic        found;
        logic [3:0]  sel;
        logic [15:0] issue;
        logic [15:0] rq;
        int unsigned expc;
        req = r; en = e; ready = rd; ovf_clr = c;
        #1;
        if (valid && ready && en) begin
            expc = (sb_q.size() > 0) ? sb_q.pop_front() : 32'd16;
            check_eq("accept_code", {28'd0, code}, expc);
        end
        load  = e && (!m_valid || rd);
        found = 1'b0;
        sel   = '0;
        for (int i = 15; i >= 0; i--) begin
            if (!found && m_pend[i]) begin
                found = 1'b1;
                sel   = 4'(i);
            end
        end
        issue = '0;
        rq    = e ? r : 16'h0;
        if (load) begin
            if (found) begin
                issue[sel] = 1'b1;
                m_code     = sel;
            end
            m_valid = found;
        end
        m_ovf  = (m_ovf & ~c) | (|(rq & m_pend & ~issue));
        m_pend = (m_pend & ~issue) | rq;
        @(posedge clk);
        #1;
        check_eq("valid", {31'd0, valid}, {31'd0, m_valid});
        if (m_valid) check_eq("code", {28'd0, code}, {28'd0, m_code});
        check_eq("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        check_eq("pending_any", {31'd0, pending_any}, {31'd0, |m_pend});
    endtask

    task automatic idle(input int n, input logic rd);
        for (int i = 0; i < n; i++) step(16'h0, 1'b1, rd, 1'b0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; en = 1'b0; req = '0; ready = 1'b0; ovf_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", {31'd0, valid}, 32'd0);
        check_eq("rst_code", {28'd0, code}, 32'd0);
        check_eq("rst_ovf", {31'd0, overflow}, 32'd0);
        check_eq("rst_pany", {31'd0, pending_any}, 32'd0);
        rst_n = 1'b1;

        // Single event, two-cycle latency
        sb_q.push_back(5);
        step(16'h0020, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1);
        check_eq("sb_single", sb_q.size(), 0);

        // Priority order
        sb_q.push_back(15); sb_q.push_back(10); sb_q.push_back(5); sb_q.push_back(0);
        step(16'h8421, 1'b1, 1'b1, 1'b0);
        idle(6, 1'b1);
        check_eq("sb_prio", sb_q.size(), 0);

        // Backpressure
        sb_q.push_back(1); sb_q.push_back(0);
        step(16'h0003, 1'b1, 1'b0, 1'b0);
        idle(5, 1'b0);
        idle(4, 1'b1);
        check_eq("sb_bp", sb_q.size(), 0);

        // Overflow by merge, clear, then clear colliding with a merge
        sb_q.push_back(4); sb_q.push_back(3);
        step(16'h0010, 1'b1, 1'b0, 1'b0);
        step(16'h0000, 1'b1, 1'b0, 1'b0);
        step(16'h0008, 1'b1, 1'b0, 1'b0);
        step(16'h0008, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1);
        step(16'h0000, 1'b1, 1'b1, 1'b1);
        sb_q.push_back(6); sb_q.push_back(5);
        step(16'h0040, 1'b1, 1'b0, 1'b0);
        step(16'h0000, 1'b1, 1'b0, 1'b0);
        step(16'h0020, 1'b1, 1'b0, 1'b0);
        step(16'h0020, 1'b1, 1'b0, 1'b1);
        idle(3, 1'b1);
        step(16'h0000, 1'b1, 1'b1, 1'b1);
        check_eq("sb_ovf", sb_q.size(), 0);

        // Re-request in the issue cycle
        sb_q.push_back(7); sb_q.push_back(7);
        step(16'h0080, 1'b1, 1'b1, 1'b0);
        step(16'h0080, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1);
        check_eq("sb_rereq", sb_q.size(), 0);

        // en low: requests ignored, presented code held
        repeat (3) step(16'hFFFF, 1'b0, 1'b1, 1'b0);
        sb_q.push_back(2);
        step(16'h0004, 1'b1, 1'b0, 1'b0);
        step(16'h0000, 1'b1, 1'b0, 1'b0);
        repeat (2) step(16'h0000, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);
        check_eq("sb_en", sb_q.size(), 0);

        // Asynchronous reset while a code is presented
        step(16'h00F0, 1'b1, 1'b0, 1'b0);
        step(16'h0000, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_valid", {31'd0, valid}, 32'd0);
        check_eq("arst_code", {28'd0, code}, 32'd0);
        check_eq("arst_ovf", {31'd0, overflow}, 32'd0);
        check_eq("arst_pany", {31'd0, pending_any}, 32'd0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle(6, 1'b1);
        check_eq("sb_final", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
